mbist_addr_seq: RTL and testbench
=================================

MBIST_ADDR_SEQ -- requirements
Module: mbist_addr_seq

Interface
REQ-001 SHALL have parameter ROW_W, default 4, meaning row address width.
REQ-002 SHALL have parameter COL_W, default 4, meaning column address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: pulse that captures the configuration and loads the first address.
REQ-006 SHALL have port adv, input, 1 bit: step the sequence by one.
REQ-007 SHALL have port dir, input, 1 bit: 0 counts up, 1 counts down; sampled at start.
REQ-008 SHALL have port order, input, 1 bit: 0 is column-fast, 1 is row-fast; sampled at start.
REQ-009 SHALL have port cmpl, input, 1 bit: 1 selects address-complement pair mode; sampled at start.
REQ-010 SHALL have ports row_lo and row_hi, input, ROW_W bits each: inclusive row window; sampled at start.
REQ-011 SHALL have port addr, output, ROW_W+COL_W bits: the current address, formatted {row, col}.
REQ-012 SHALL have output port busy, 1 bit; output port first, 1 bit; output port last, 1 bit; output port done, 1 bit; output port cfg_err, 1 bit; output port bg, 1 bit.

Function
REQ-013 SHALL implement states IDLE and RUN.
REQ-014 On start with row_lo<=row_hi, SHALL enter RUN at the next edge with row=dir?row_hi:row_lo, col=dir?COL_MAX:0, phase=0, and cfg_err=0.
REQ-015 On start with row_lo>row_hi, SHALL go to IDLE, set cfg_err=1 (sticky until the next start), and leave addr unchanged.
REQ-016 start SHALL be accepted in any state; start and adv in the same cycle means start wins and adv is ignored.
REQ-017 adv in IDLE SHALL be ignored; adv=0 in RUN SHALL hold all state.
REQ-018 In RUN, adv SHALL step the fast axis by +1 (up) or -1 (down). Column range is 0..COL_MAX. Row range is row_lo..row_hi.
REQ-019 When the fast axis wraps (max->min going up, min->max going down), the fast axis SHALL reload its start bound and the slow axis SHALL step by ±1 in the same cycle.
REQ-020 With cmpl=1, each adv SHALL toggle phase; the row/col counters SHALL step only on adv while phase=1; addr SHALL equal ~{row,col} while phase=1 and {row,col} otherwise.
REQ-021 last SHALL be combinational: 1 in RUN at the terminal address (up: row_hi,COL_MAX; down: row_lo,0), and additionally phase=1 when cmpl=1.
REQ-022 first SHALL be 1 in RUN at the start address with phase=0.
REQ-023 adv while last=1 SHALL return the block to IDLE, assert done for exactly one cycle, and hold addr at its terminal value.
REQ-024 busy SHALL be 1 exactly in RUN.
REQ-025 bg SHALL equal row[0]^col[0] (checkerboard background) and be valid in every state.
REQ-026 Total advs per pass SHALL be (row_hi-row_lo+1)*(COL_MAX+1)*(cmpl?2:1).

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with row=0, col=0, phase=0, and addr, busy, done, cfg_err all 0, irrespective of the clock.
REQ-028 Reset mid-RUN SHALL abort the pass with no done pulse; the first edge after release SHALL require start before any stepping.

Structure
REQ-029 Package mbist_pkg SHALL hold the state encoding and the dir/order constants (UP, DOWN, COL_FAST, ROW_FAST).
REQ-030 A bounded up/down counter sub-module mbist_bound_cnt SHALL be provided, with ports lo, hi, dir, load, step, and outputs value and wrap. It SHALL be instantiated once for the row axis and once for the column axis.
REQ-031 The fast/slow axis selection SHALL be muxed at the step and wrap ports only; no duplicated counters.

Verification
REQ-032 (ROW_W=COL_W=4) start dir=0 order=0 lo=0 hi=15 cmpl=0, adv held 1 -> addr 0x00,0x01..0x0F,0x10..0xFF; done pulses once after the 256th adv; busy falls with it.
REQ-033 start dir=1 order=1 lo=2 hi=5 -> addr 0x5F,0x4F,0x3F,0x2F,0x5E..; last at 0x20; done after 64 advs.
REQ-034 start cmpl=1 dir=0 lo=0 hi=0 -> addr 0x00,0xFF,0x01,0xFE..0x0F,0xF0; done after 32 advs.
REQ-035 start lo=7 hi=3 -> cfg_err=1, busy=0; subsequent advs leave addr unchanged; a valid start clears cfg_err.
REQ-036 At addr 0x3A in RUN: start+adv in the same cycle -> next addr is the new start address. Separately, rst_n low -> addr=0 and busy=0 without a clock edge, and no done pulse.
REQ-037 adv pattern 1,0,1,0 from 0x11 -> addr 0x12 held for two cycles then 0x13; bg=1 at 0x12 and 0 at 0x13.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared constants for the MBIST address sequencer: FSM encoding, direction/order
// codes and the captured pass configuration.
package mbist_pkg;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    localparam logic UP       = 1'b0;
    localparam logic DOWN     = 1'b1;
    localparam logic COL_FAST = 1'b0;
    localparam logic ROW_FAST = 1'b1;

    typedef struct packed {
        logic dir;
        logic order;
        logic cmpl;
    } mode_t;

endpackage

// File: rtl/mbist_bound_cnt.sv
// Up/down counter confined to an inclusive [lo, hi] window that reloads on wrap.
// wrap flags that the next step would cross the end bound for the current direction.
module mbist_bound_cnt
    import mbist_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic         dir,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    // wrap depends only on the current value, so the axis mux in the parent stays loop-free
    assign wrap = (dir == DOWN) ? (value == lo) : (value == hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= (dir == DOWN) ? hi : lo;
        end else if (step) begin
            if (wrap) begin
                value <= (dir == DOWN) ? hi : lo;
            end else if (dir == DOWN) begin
                value <= value - ONE;
            end else begin
                value <= value + ONE;
            end
        end
    end

endmodule

// File: rtl/mbist_addr_seq.sv
// MBIST address sequencer: walks a {row, col} window in either direction and order,
// with an optional true/complement address pair per location.
module mbist_addr_seq
    import mbist_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   adv,
    input  logic                   dir,
    input  logic                   order,
    input  logic                   cmpl,
    input  logic [ROW_W-1:0]       row_lo,
    input  logic [ROW_W-1:0]       row_hi,
    output logic [ROW_W+COL_W-1:0] addr,
    output logic                   busy,
    output logic                   first,
    output logic                   last,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   bg
);

    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [COL_W-1:0] COL_MIN = '0;

    logic [0:0]       state_q;
    mode_t            mode_q;
    logic [ROW_W-1:0] lo_q;
    logic [ROW_W-1:0] hi_q;
    logic             phase_q;
    logic             done_q;
    logic             cfg_err_q;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             row_wrap;
    logic             col_wrap;
    logic             row_step;
    logic             col_step;
    logic             fast_step;
    logic             run;
    logic             cfg_bad;
    logic             load;
    logic             adv_run;
    logic             cnt_dir;
    logic [ROW_W-1:0] cnt_lo;
    logic [ROW_W-1:0] cnt_hi;
    logic [ROW_W-1:0] term_row;
    logic [COL_W-1:0] term_col;
    logic [ROW_W-1:0] first_row;
    logic [COL_W-1:0] first_col;

    assign run     = (state_q == STATE_RUN);
    assign cfg_bad = (row_lo > row_hi);
    assign load    = start && !cfg_bad;
    assign adv_run = run && adv && !start;

    // On the start cycle the counters load from the incoming configuration
    assign cnt_dir = start ? dir    : mode_q.dir;
    assign cnt_lo  = start ? row_lo : lo_q;
    assign cnt_hi  = start ? row_hi : hi_q;

    assign term_row  = (mode_q.dir == DOWN) ? lo_q    : hi_q;
    assign term_col  = (mode_q.dir == DOWN) ? COL_MIN : COL_MAX;
    assign first_row = (mode_q.dir == DOWN) ? hi_q    : lo_q;
    assign first_col = (mode_q.dir == DOWN) ? COL_MAX : COL_MIN;

    assign last  = run && (row == term_row) && (col == term_col) && (!mode_q.cmpl || phase_q);
    assign first = run && !phase_q && (row == first_row) && (col == first_col);

    // Counters freeze on the terminal address so addr holds once the pass ends
    assign fast_step = adv_run && !last && (!mode_q.cmpl || phase_q);
    assign row_step  = (mode_q.order == ROW_FAST) ? fast_step : (fast_step && col_wrap);
    assign col_step  = (mode_q.order == ROW_FAST) ? (fast_step && row_wrap) : fast_step;

    mbist_bound_cnt #(.W(ROW_W)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .lo    (cnt_lo),
        .hi    (cnt_hi),
        .dir   (cnt_dir),
        .load  (load),
        .step  (row_step),
        .value (row),
        .wrap  (row_wrap)
    );

    mbist_bound_cnt #(.W(COL_W)) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .lo    (COL_MIN),
        .hi    (COL_MAX),
        .dir   (cnt_dir),
        .load  (load),
        .step  (col_step),
        .value (col),
        .wrap  (col_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STATE_IDLE;
            mode_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            phase_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                cfg_err_q <= cfg_bad;
                if (cfg_bad) begin
                    state_q <= STATE_IDLE;
                end else begin
                    state_q <= STATE_RUN;
                    mode_q  <= '{dir: dir, order: order, cmpl: cmpl};
                    lo_q    <= row_lo;
                    hi_q    <= row_hi;
                    phase_q <= 1'b0;
                end
            end else if (adv_run) begin
                if (last) begin
                    state_q <= STATE_IDLE;
                    done_q  <= 1'b1;
                end else if (mode_q.cmpl) begin
                    phase_q <= ~phase_q;
                end
            end
        end
    end

    assign addr    = phase_q ? ~{row, col} : {row, col};
    assign busy    = run;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign bg      = row[0] ^ col[0];

endmodule

// File: tb/tb_mbist_addr_seq.sv
// Directed bench for mbist_addr_seq (ROW_W = COL_W = 4) with hand-derived address sequences.
module tb_mbist_addr_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       adv;
    logic       dir;
    logic       order;
    logic       cmpl;
    logic [3:0] row_lo;
    logic [3:0] row_hi;
    logic [7:0] addr;
    logic       busy;
    logic       first;
    logic       last;
    logic       done;
    logic       cfg_err;
    logic       bg;

    int checks;
    int fails;

    mbist_addr_seq #(.ROW_W(4), .COL_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .adv     (adv),
        .dir     (dir),
        .order   (order),
        .cmpl    (cmpl),
        .row_lo  (row_lo),
        .row_hi  (row_hi),
        .addr    (addr),
        .busy    (busy),
        .first   (first),
        .last    (last),
        .done    (done),
        .cfg_err (cfg_err),
        .bg      (bg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic d, input logic o, input logic c,
                            input logic [3:0] lo, input logic [3:0] hi, input logic a);
        dir = d; order = o; cmpl = c; row_lo = lo; row_hi = hi;
        start = 1'b1; adv = a;
        tick();
        start = 1'b0; adv = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; adv = 1'b0; dir = 1'b0; order = 1'b0; cmpl = 1'b0;
        row_lo = 4'h0; row_hi = 4'hF;
        #3;
        checks++; if (addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_addr got %h want 00", addr); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (cfg_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_cfg_err got %b want 0", cfg_err); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_col_fast_up();
        logic [7:0] exp;
        do_start(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        checks++; if (busy !== 1'b1 || first !== 1'b1) begin fails++; $display("[TB] FAIL up_start_flags got busy=%b first=%b want 1 1", busy, first); end
        adv = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp = 8'(i);
            checks++; if (addr !== exp) begin fails++; $display("[TB] FAIL up_addr[%0d] got %h want %h", i, addr, exp); end
            checks++; if (last !== (i == 255)) begin fails++; $display("[TB] FAIL up_last[%0d] got %b want %b", i, last, (i == 255)); end
            tick();
            checks++; if (done !== (i == 255)) begin fails++; $display("[TB] FAIL up_done[%0d] got %b want %b", i, done, (i == 255)); end
        end
        adv = 1'b0;
        checks++; if (busy !== 1'b0 || addr !== 8'hFF) begin fails++; $display("[TB] FAIL up_end got busy=%b addr=%h want 0 ff", busy, addr); end
        tick();
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL up_done_width got %b want 0", done); end
    endtask

    task automatic test_row_fast_down();
        logic [3:0] r;
        logic [3:0] c;
        do_start(1'b1, 1'b1, 1'b0, 4'h2, 4'h5, 1'b0);
        adv = 1'b1;
        for (int k = 0; k < 64; k++) begin
            r = 4'(5 - (k % 4));
            c = 4'(15 - (k / 4));
            checks++; if (addr !== {r, c}) begin fails++; $display("[TB] FAIL down_addr[%0d] got %h want %h", k, addr, {r, c}); end
            checks++; if (first !== (k == 0) || last !== (k == 63)) begin fails++; $display("[TB] FAIL down_flags[%0d] got first=%b last=%b", k, first, last); end
            tick();
            checks++; if (done !== (k == 63)) begin fails++; $display("[TB] FAIL down_done[%0d] got %b want %b", k, done, (k == 63)); end
        end
        adv = 1'b0;
        checks++; if (addr !== 8'h20 || busy !== 1'b0) begin fails++; $display("[TB] FAIL down_end got addr=%h busy=%b want 20 0", addr, busy); end
    endtask

    task automatic test_complement();
        logic [7:0] exp;
        do_start(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        adv = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp = {4'h0, 4'(k / 2)};
            if (k % 2 == 1) exp = ~exp;
            checks++; if (addr !== exp) begin fails++; $display("[TB] FAIL cmpl_addr[%0d] got %h want %h", k, addr, exp); end
            checks++; if (last !== (k == 31)) begin fails++; $display("[TB] FAIL cmpl_last[%0d] got %b want %b", k, last, (k == 31)); end
            tick();
            checks++; if (done !== (k == 31)) begin fails++; $display("[TB] FAIL cmpl_done[%0d] got %b want %b", k, done, (k == 31)); end
        end
        adv = 1'b0;
        checks++; if (addr !== 8'hF0) begin fails++; $display("[TB] FAIL cmpl_hold got %h want f0", addr); end
    endtask

    task automatic test_cfg_err();
        do_start(1'b0, 1'b0, 1'b0, 4'h7, 4'h3, 1'b0);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL cfgerr_set got err=%b busy=%b want 1 0", cfg_err, busy); end
        checks++; if (addr !== 8'hF0) begin fails++; $display("[TB] FAIL cfgerr_addr got %h want f0", addr); end
        adv = 1'b1;
        tick(); tick(); tick();
        adv = 1'b0;
        checks++; if (addr !== 8'hF0 || cfg_err !== 1'b1) begin fails++; $display("[TB] FAIL cfgerr_adv got addr=%h err=%b want f0 1", addr, cfg_err); end
        do_start(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        checks++; if (cfg_err !== 1'b0 || addr !== 8'h00 || busy !== 1'b1) begin fails++; $display("[TB] FAIL cfgerr_clear got err=%b addr=%h busy=%b", cfg_err, addr, busy); end
    endtask

    task automatic test_start_wins();
        adv = 1'b1;
        for (int i = 0; i < 58; i++) tick();
        adv = 1'b0;
        checks++; if (addr !== 8'h3A) begin fails++; $display("[TB] FAIL restart_pre got %h want 3a", addr); end
        do_start(1'b1, 1'b0, 1'b0, 4'h1, 4'h4, 1'b1);
        checks++; if (addr !== 8'h4F || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("[TB] FAIL restart got addr=%h busy=%b done=%b want 4f 1 0", addr, busy, done); end
    endtask

    task automatic test_reset_mid_run();
        adv = 1'b1;
        tick(); tick();
        adv = 1'b0;
        checks++; if (addr !== 8'h4D) begin fails++; $display("[TB] FAIL midrst_pre got %h want 4d", addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (addr !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_async got addr=%h busy=%b done=%b", addr, busy, done); end
        adv = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (addr !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_after[%0d] got addr=%h busy=%b done=%b", i, addr, busy, done); end
        end
        adv = 1'b0;
    endtask

    task automatic test_adv_pattern();
        logic [3:0] pat;
        logic [7:0] exp_addr [4];
        logic       exp_bg   [4];
        pat = 4'b0101;
        exp_addr = '{8'h12, 8'h12, 8'h13, 8'h13};
        exp_bg   = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_start(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        adv = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        adv = 1'b0;
        checks++; if (addr !== 8'h11 || bg !== 1'b0) begin fails++; $display("[TB] FAIL pat_pre got addr=%h bg=%b want 11 0", addr, bg); end
        for (int i = 0; i < 4; i++) begin
            adv = pat[i];
            tick();
            checks++; if (addr !== exp_addr[i] || bg !== exp_bg[i]) begin fails++; $display("[TB] FAIL pat[%0d] got addr=%h bg=%b want %h %b", i, addr, bg, exp_addr[i], exp_bg[i]); end
        end
        adv = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_col_fast_up();
        test_row_fast_down();
        test_complement();
        test_cfg_err();
        test_start_wins();
        test_reset_mid_run();
        test_adv_pattern();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
